instruction_fetch: RTL and testbench

Fetch front end that initiates every read of the 4096×19-bit instruction memory. It owns the program counter and drives `address` to the memory. It registers the returned `instruction` into a one-entry output stage with a valid/ready handshake toward decode. Taken jumps and branches redirect it. It sits between the instruction memory and the decode/control block of the single-cycle/multi-cycle CPU datapath.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/fetch_next_pc.sv | 27 ++
 rtl/instruction_fetch.sv | 78 +++++++
 tb/tb_instruction_fetch.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: instruction/address widths, fetch FSM states
// and the redirect request bundle passed to the next-PC logic.
package cpu_pkg;
  localparam int ADDR_W = 12;
  localparam int INST_W = 19;
  localparam int OFS_W  = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;
  typedef logic [OFS_W-1:0]  ofs_t;

  typedef enum logic [1:0] {RESET, RUN, FLUSH} fetch_state_t;

  typedef struct packed {
    logic  valid;
    logic  rel;
    addr_t target;
    addr_t base;
    ofs_t  ofs;
  } redir_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch bundle: memory address/data, decode valid/ready stage and redirect inputs.
interface instruction_fetch_if;
  import cpu_pkg::*;

  addr_t address;
  inst_t instruction;
  inst_t inst_out;
  addr_t inst_pc;
  logic  inst_valid;
  logic  inst_ready;
  logic  redir_valid;
  logic  redir_rel;
  addr_t redir_target;
  addr_t redir_base;
  ofs_t  redir_ofs;

  modport master (
    output address, inst_out, inst_pc, inst_valid,
    input  instruction, inst_ready, redir_valid, redir_rel,
           redir_target, redir_base, redir_ofs
  );

  modport slave (
    input  address, inst_out, inst_pc, inst_valid,
    output instruction, inst_ready, redir_valid, redir_rel,
           redir_target, redir_base, redir_ofs
  );
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: redirect target, sequential step or hold.
module fetch_next_pc
  import cpu_pkg::*;
(
  input  addr_t        pc_i,
  input  logic         stage_free_i,
  input  redir_t       redir_i,
  input  fetch_state_t state_i,
  output addr_t        next_pc_o
);
  addr_t ofs_sext;
  addr_t rel_tgt;

  // Relative targets count from the instruction after the branch.
  assign ofs_sext = {{(ADDR_W-OFS_W){redir_i.ofs[OFS_W-1]}}, redir_i.ofs};
  assign rel_tgt  = redir_i.base + addr_t'(1) + ofs_sext;

  always_comb begin
    next_pc_o = pc_i;
    if (state_i != RESET) begin
      if (redir_i.valid)
        next_pc_o = redir_i.rel ? rel_tgt : redir_i.target;
      else if (state_i == RUN && stage_free_i)
        next_pc_o = pc_i + addr_t'(1);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: PC register, RESET/RUN/FLUSH sequencing and a one-entry
// valid/ready output stage toward decode.
module instruction_fetch
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master fif
);
  fetch_state_t state_q, state_d;
  addr_t        pc_q, pc_d;
  inst_t        inst_q, inst_d;
  addr_t        ipc_q, ipc_d;
  logic         vld_q, vld_d;
  logic         stage_free;
  redir_t       redir;

  assign stage_free = !vld_q || fif.inst_ready;
  assign redir = '{valid:  fif.redir_valid,
                   rel:    fif.redir_rel,
                   target: fif.redir_target,
                   base:   fif.redir_base,
                   ofs:    fif.redir_ofs};

  fetch_next_pc u_next_pc (
    .pc_i        (pc_q),
    .stage_free_i(stage_free),
    .redir_i     (redir),
    .state_i     (state_q),
    .next_pc_o   (pc_d)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    unique case (state_q)
      RESET: state_d = RUN;
      RUN, FLUSH: begin
        // Redirect beats stall: an unaccepted word is simply dropped.
        if (redir.valid) begin
          vld_d   = 1'b0;
          state_d = FLUSH;
        end else if (state_q == FLUSH) begin
          vld_d   = 1'b0;
          state_d = RUN;
        end else if (stage_free) begin
          inst_d = fif.instruction;
          ipc_d  = pc_q;
          vld_d  = 1'b1;
        end
      end
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET;
      pc_q    <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
    end
  end

  assign fif.address    = pc_q;
  assign fif.inst_out   = inst_q;
  assign fif.inst_pc    = ipc_q;
  assign fif.inst_valid = vld_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus queues expected accepted
// PCs, a negedge monitor checks every handshake against the memory model.
module tb_instruction_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  addr_t exp_q[$];

  instruction_fetch_if fif();

  instruction_fetch dut (
    .clk(clk),
    .rst(rst),
    .fif(fif)
  );

  always #5 clk = ~clk;

  function automatic inst_t memf(addr_t a);
    return {a[6:0] ^ 7'h2A, a};
  endfunction

  assign fif.instruction = memf(fif.address);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle redirect and walk through the fixed two-cycle bubble.
  task automatic redirect(logic rel, addr_t tgt, addr_t base, ofs_t ofs,
                          logic rdy, addr_t exp);
    fif.redir_valid  = 1'b1;
    fif.redir_rel    = rel;
    fif.redir_target = tgt;
    fif.redir_base   = base;
    fif.redir_ofs    = ofs;
    fif.inst_ready   = rdy;
    step(1);
    fif.redir_valid = 1'b0;
    fif.inst_ready  = 1'b1;
    chk("redir_address", 32'(fif.address), 32'(exp));
    chk("redir_bubble1", 32'(fif.inst_valid), 32'd0);
    step(1);
    chk("redir_bubble2", 32'(fif.inst_valid), 32'd0);
    exp_q.push_back(exp);
    step(1);
    chk("redir_arrive_valid", 32'(fif.inst_valid), 32'd1);
    chk("redir_arrive_pc", 32'(fif.inst_pc), 32'(exp));
  endtask

  // Monitor: every accepted word must be the next one the scoreboard expects.
  always @(negedge clk) begin
    if (fif.inst_valid === 1'b1 && fif.inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_accept: got pc %0h expected none", fif.inst_pc);
      end else begin
        automatic addr_t e = exp_q.pop_front();
        chk("accept_pc", 32'(fif.inst_pc), 32'(e));
        chk("accept_inst", 32'(fif.inst_out), 32'(memf(e)));
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    fif.inst_ready   = 1'b1;
    fif.redir_valid  = 1'b0;
    fif.redir_rel    = 1'b0;
    fif.redir_target = '0;
    fif.redir_base   = '0;
    fif.redir_ofs    = '0;
    step(2);
    chk("rst_valid", 32'(fif.inst_valid), 32'd0);
    chk("rst_address", 32'(fif.address), 32'd0);
    chk("rst_inst_out", 32'(fif.inst_out), 32'd0);
    chk("rst_inst_pc", 32'(fif.inst_pc), 32'd0);
    for (int i = 0; i < 10; i++) exp_q.push_back(addr_t'(i));
    rst = 1'b0;
    step(1);
    chk("reset_hold_valid", 32'(fif.inst_valid), 32'd0);
    chk("reset_hold_address", 32'(fif.address), 32'd0);
    step(1);
    chk("first_valid", 32'(fif.inst_valid), 32'd1);
    chk("first_pc", 32'(fif.inst_pc), 32'd0);
    step(5);
    chk("pre_stall_pc", 32'(fif.inst_pc), 32'd5);

    fif.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_valid", 32'(fif.inst_valid), 32'd1);
      chk("stall_pc", 32'(fif.inst_pc), 32'd5);
      chk("stall_inst", 32'(fif.inst_out), 32'(memf(12'd5)));
      chk("stall_address", 32'(fif.address), 32'd6);
    end
    fif.inst_ready = 1'b1;
    step(4);
    chk("post_stall_pc", 32'(fif.inst_pc), 32'd9);

    redirect(1'b0, 12'd20, 12'd0, 8'h00, 1'b1, 12'd20);
    exp_q.push_back(12'd21);
    step(1);
    chk("seq_after_redir", 32'(fif.inst_pc), 32'd21);
    redirect(1'b1, 12'd0, 12'd25, 8'h03, 1'b1, 12'd29);
    redirect(1'b1, 12'd0, 12'd30, 8'h80, 1'b1, 12'd3999);
    redirect(1'b1, 12'd0, 12'd0, 8'hFF, 1'b1, 12'd0);
    redirect(1'b0, 12'd4094, 12'd0, 8'h00, 1'b1, 12'd4094);
    exp_q.push_back(12'd4095);
    step(1);
    chk("top_pc", 32'(fif.inst_pc), 32'd4095);
    step(1);
    fif.inst_ready = 1'b0;
    chk("wrap_pc", 32'(fif.inst_pc), 32'd0);
    chk("wrap_address", 32'(fif.address), 32'd1);
    // Pending word 0 is never accepted, so it is not queued.
    redirect(1'b0, 12'd50, 12'd0, 8'h00, 1'b0, 12'd50);
    redirect(1'b0, 12'd98, 12'd0, 8'h00, 1'b1, 12'd98);
    exp_q.push_back(12'd99);
    step(1);
    chk("pre_rst_address", 32'(fif.address), 32'd100);

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_valid", 32'(fif.inst_valid), 32'd0);
    chk("midrst_address", 32'(fif.address), 32'd0);
    chk("midrst_inst_out", 32'(fif.inst_out), 32'd0);
    for (int i = 0; i < 3; i++) exp_q.push_back(addr_t'(i));
    step(1);
    chk("midrst_hold_valid", 32'(fif.inst_valid), 32'd0);
    step(1);
    chk("restart_pc", 32'(fif.inst_pc), 32'd0);
    chk("restart_valid", 32'(fif.inst_valid), 32'd1);
    step(2);
    @(negedge clk);
    #1;
    fif.inst_ready = 1'b0;
    step(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
